// File: rtl/proc_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : proc_nios2_qsys_0_oci_dct_packer
// Brief    : Packs 2-bit trace atoms LSB-first into 30-bit DCT words with an
//            atom count, presented downstream on a valid/ready handshake.
//            Optional macro PROC_OCI_DCT_DROP_EN selects lossy mode: the
//            atom side never stalls, atoms offered while a sealed word waits
//            are discarded and counted in drop_count.
// Revision : 1.0 - initial release
// ============================================================================
module proc_nios2_qsys_0_oci_dct_packer #(
  parameter  int ATOM_W = 2,
  parameter  int ATOMS  = 15,
  localparam int BUF_W  = ATOM_W * ATOMS,
  localparam int CNT_W  = $clog2(ATOMS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready
`ifdef PROC_OCI_DCT_DROP_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    SEALED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUF_W-1:0]   r_acc;
  logic [BUF_W-1:0]   w_acc_ins;
  logic [BUF_W-1:0]   w_acc_nxt;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic [CNT_W-1:0]   w_n;
  logic [CNT_W-1:0]   w_acc_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_seal;
  logic               w_out_free;
  logic               w_load;
  logic               w_valid_nxt;

  // Atoms only enter the accumulator while filling; in lossy mode the
  // handshake still reads ready, but a sealed accumulator ignores the atom.
  assign w_accept   = atom_valid & (r_state == FILL);
`ifdef PROC_OCI_DCT_DROP_EN
  assign atom_ready = 1'b1;
`else
  assign atom_ready = (r_state == FILL);
`endif

  // High accumulator bits are always zero, so OR-ing in the new atom is enough.
  assign w_acc_ins  = w_accept ? (r_acc | (BUF_W'(atom) << (r_acc_cnt * ATOM_W))) : r_acc;
  assign w_n        = r_acc_cnt + CNT_W'(w_accept);
  assign w_seal     = (w_n == CNT_W'(ATOMS)) | (flush & (w_n != '0));
  assign w_out_free = ~dct_valid | dct_ready;

  // Next-state, accumulator update and output-register load decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_acc_cnt_nxt = r_acc_cnt;
    w_load        = 1'b0;
    w_buf_nxt     = r_acc;
    w_cnt_nxt     = r_acc_cnt;
    case (r_state)
      FILL: begin
        if (w_seal && w_out_free) begin
          w_load        = 1'b1;
          w_buf_nxt     = w_acc_ins;
          w_cnt_nxt     = w_n;
          w_acc_nxt     = '0;
          w_acc_cnt_nxt = '0;
        end else begin
          w_acc_nxt     = w_acc_ins;
          w_acc_cnt_nxt = w_n;
          if (w_seal) begin
            w_state_nxt = SEALED;
          end
        end
      end
      SEALED: begin
        if (w_out_free) begin
          w_load        = 1'b1;
          w_acc_nxt     = '0;
          w_acc_cnt_nxt = '0;
          w_state_nxt   = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
    // A load keeps valid high even when the consumer takes the old word.
    w_valid_nxt = w_load | (dct_valid & ~dct_ready);
  end

  // State register and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FILL;
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_acc_cnt <= w_acc_cnt_nxt;
    end
  end

  // Output register; buffer and count hold their last values after a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else begin
      dct_valid <= w_valid_nxt;
      if (w_load) begin
        dct_buffer <= w_buf_nxt;
        dct_count  <= w_cnt_nxt;
      end
    end
  end

`ifdef PROC_OCI_DCT_DROP_EN
  // Saturating count of atoms discarded while a sealed word waits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if ((r_state == SEALED) && atom_valid && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_proc_nios2_qsys_0_oci_dct_packer
// Brief    : Scoreboard bench for the DCT atom packer. A queue-based model
//            predicts every emitted word; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'd0;
  logic        flush = 1'b0;
  logic        dct_ready = 1'b0;
  logic        atom_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
`ifdef PROC_OCI_DCT_DROP_EN
  logic [15:0] drop_count;
`endif

  proc_nios2_qsys_0_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .atom_valid (atom_valid),
    .atom       (atom),
    .atom_ready (atom_ready),
    .flush      (flush),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .dct_valid  (dct_valid),
    .dct_ready  (dct_ready)
`ifdef PROC_OCI_DCT_DROP_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [29:0] b;
    logic [3:0]  c;
  } word_t;

  word_t exp_q[$];
  int    m_cur[$];
  word_t m_held;
  bit    m_sealed;
  bit    m_outv;
  int    m_drop;
  bit    m_free;
  bit    m_load;

  // Word value: atom k contributes atom * 4^k.
  function automatic word_t pack(input int q[$]);
    word_t  w;
    longint acc;
    acc = 0;
    foreach (q[k]) acc += longint'(q[k]) << (2 * k);
    w.b = acc[29:0];
    w.c = 4'(q.size());
    return w;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cur.delete();
      m_sealed = 1'b0;
      m_outv   = 1'b0;
      m_drop   = 0;
    end else begin
      m_free = !m_outv || dct_ready;
      m_load = 1'b0;
      if (m_sealed) begin
        if (atom_valid && m_drop < 65535) m_drop++;
        if (m_free) begin
          exp_q.push_back(m_held);
          m_sealed = 1'b0;
          m_load   = 1'b1;
        end
      end else begin
        if (atom_valid) m_cur.push_back(int'(atom));
        if (m_cur.size() == 15 || (flush && m_cur.size() > 0)) begin
          if (m_free) begin
            exp_q.push_back(pack(m_cur));
            m_load = 1'b1;
          end else begin
            m_held   = pack(m_cur);
            m_sealed = 1'b1;
          end
          m_cur.delete();
        end
      end
      if (m_load) m_outv = 1'b1;
      else if (dct_ready) m_outv = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  word_t got_w;
  bit    exp_ready;

  always @(negedge clk) begin
    if (reset_n) begin
`ifdef PROC_OCI_DCT_DROP_EN
      exp_ready = 1'b1;
      chk("drop_count", drop_count, m_drop);
`else
      exp_ready = !m_sealed;
`endif
      chk("atom_ready", atom_ready, exp_ready);
      chk("dct_valid", dct_valid, m_outv);
      if (dct_valid && dct_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got buffer %0h count %0d, expected no word", dct_buffer, dct_count);
        end else begin
          got_w = exp_q.pop_front();
          chk("word_buffer", dct_buffer, got_w.b);
          chk("word_count", dct_count, got_w.c);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [1:0] a, input bit f, input bit r);
    atom_valid = v;
    atom       = a;
    flush      = f;
    dct_ready  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_atom_ready", atom_ready, 1);
    chk("rst_dct_valid", dct_valid, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_dct_count", dct_count, 0);

    // Full word of atoms k mod 4.
    for (int k = 0; k < 15; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b1);
    chk("full_valid", dct_valid, 1);
    chk("full_buffer", dct_buffer, 30'h24E4E4E4);
    chk("full_count", dct_count, 15);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    chk("full_drained", dct_valid, 0);

    // Flush a 3-atom partial word, then flush with nothing pending.
    cyc(1'b1, 2'd3, 1'b0, 1'b1);
    cyc(1'b1, 2'd2, 1'b0, 1'b1);
    cyc(1'b1, 2'd1, 1'b1, 1'b1);
    chk("flush_valid", dct_valid, 1);
    chk("flush_buffer", dct_buffer, 30'h1B);
    chk("flush_count", dct_count, 3);
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, 1'b1, 1'b1);
    chk("empty_flush_valid", dct_valid, 0);

    // Backpressure: 30 atoms with the consumer stalled.
    for (int k = 0; k < 30; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
`ifndef PROC_OCI_DCT_DROP_EN
    chk("bp_atom_ready", atom_ready, 0);
`endif
    chk("bp_valid", dct_valid, 1);
    chk("bp_count", dct_count, 15);
`ifdef PROC_OCI_DCT_DROP_EN
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("drop_five", drop_count, 5);
    chk("drop_atom_ready", atom_ready, 1);
`endif
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, 1'b0, 1'b1);

    // Simultaneous drain of old word and load of a full word.
    cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
    chk("simul_valid", dct_valid, 1);
    chk("simul_count", dct_count, 15);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);

    // Asynchronous reset pulse mid-word.
    for (int k = 0; k < 7; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", dct_valid, 0);
    chk("mid_rst_buffer", dct_buffer, 0);
    chk("mid_rst_count", dct_count, 0);
    chk("mid_rst_atom_ready", atom_ready, 1);
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
    chk("post_rst_valid", dct_valid, 1);
    chk("post_rst_count", dct_count, 15);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);

    // Drain everything still pending.
    for (int k = 0; k < 10; k++) cyc(1'b0, 2'd0, 1'b1, 1'b1);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_valid", dct_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
